jk_excitation_counter: RTL
==========================

Name: jk_excitation_counter

Overview:
- Synchronous up/down counter whose state bits are JK cells. Each bit is driven by J/K excitation computed from the current and required next state, i.e. the excitation table, the inverse of the JK characteristic table.
- Supplies the lab's counter/sequencer exercises.
- Exposes the per-bit J/K vectors so that benches and front-panel LEDs can observe the excitation.
- A small FSM controls run, stop-at-target and load.

Parameters:
WIDTH, 4, counter width in bits (2..16)

Ports:
clk       input   1      clock; all state changes on rising edge
rst       input   1      synchronous reset, active-high
en        input   1      count enable
up        input   1      1 = count up, 0 = count down
load      input   1      synchronous parallel load request
load_val  input   WIDTH  value loaded when load=1
stop_en   input   1      1 = stop when count reaches stop_val
stop_val  input   WIDTH  target count
q         output  WIDTH  counter state (registered)
qnot      output  WIDTH  bitwise ~q
j         output  WIDTH  J excitation applied at the coming edge (combinational)
k         output  WIDTH  K excitation applied at the coming edge (combinational)
tc        output  1      terminal count (combinational)
done      output  1      1 while FSM in DONE (registered)
state     output  2      FSM state: 00 IDLE, 01 RUN, 10 DONE

Behaviour:
- Reset: rst=1 at a rising edge sets q=0, state=IDLE and done=0. rst has priority over every other input.
- Update rule: q updates only through the JK characteristic, per bit:
  - J=0,K=0: hold
  - J=0,K=1: clear
  - J=1,K=0: set
  - J=1,K=1: toggle
- Target selection: the required next value n is chosen by priority:
  1. load=1: n = load_val
  2. state=RUN: n = q+1 if up, q-1 if down, modulo 2^WIDTH (wraps at all-ones and 0)
  3. otherwise: n = q
- Default excitation, per bit, from (q_i -> n_i):
  - 0->0: J=0,K=0
  - 0->1: J=1,K=0
  - 1->0: J=0,K=1
  - 1->1: J=0,K=0
  - Don't-cares resolve to 0, so toggle is never issued.
- j/k while rst=1: forced to 0.
- j/k timing: combinational and valid throughout the cycle. The value visible in a cycle is the value consumed at that cycle's closing edge.
- FSM (evaluated after rst; load handled first):
  - load=1, any state: q<=load_val; state<=RUN if en=1, else IDLE; done<=0.
  - IDLE: en=1 -> RUN. No count occurs on the transition edge; counting starts the following edge.
  - RUN:
    - en=0: -> IDLE, no count on that edge.
    - stop_en=1 and n==stop_val: q<=n, state<=DONE, done<=1.
    - Otherwise: q<=n.
  - DONE: q holds.
    - en=0: -> IDLE, done<=0.
    - stop_en=0: -> RUN.
    - load: handled above.
- Stop at entry: if stop_en=1 and q already equals stop_val on entry to RUN, the counter continues. The stop is checked only against the next value n.
- tc = (state==RUN) & ((up & q==all-ones) | (~up & q==0)). It marks the cycle before wrap.
- up change: up may change at any cycle and takes effect at the next edge.
- Reset mid-run: returns to q=0, IDLE. No pending load or stop is retained.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- Defined: excitation uses the toggle-form don't-care resolution.
  - 0->1 and 1->0: J=1,K=1
  - 0->0 and 1->1: J=0,K=0
- Undefined: the default table above applies.
- q, qnot, tc, done and state sequences are identical in both builds; only j/k differ.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then en=0 for 5 cycles -> q=0, qnot=4'hF, state=00, done=0, j=k=0 throughout.
- Up count with wrap: WIDTH=4, load_val=4'hE with load=1 and en=1, then en=1, up=1:
  - q sequence E,F,0,1
  - tc=1 only while q=F
  - at q=7->8 the default build shows j=4'b1000, k=4'b0111
- Down count and stop: load 4'h5, up=0, stop_en=1, stop_val=4'h2, en=1 -> q goes 5,4,3,2; state=10 and done=1 in the cycle q=2; q stays 2 for 5 further cycles.
- Simultaneous load: in RUN at q=3, up=1, assert load=1 with load_val=4'hA -> next q=A (not 4), state stays RUN; default-build j=4'b1000, k=4'b0001 in that cycle.
- Pause/resume and reset mid-run: q=6 in RUN, en=0 for 3 cycles -> q holds 6 in IDLE; en=1 -> one idle edge, then q=7; assert rst mid-count -> q=0, IDLE at the next edge.
- JK_TOGGLE_EN build: repeat the up-count scenario -> identical q trace; at q=7->8, j=k=4'b1111.

Source files
------------

// File: rtl/jk_excitation_counter.sv
// Up/down counter built from JK cells, with excitation derived from the current and target state.
// Optional macro JK_TOGGLE_EN selects toggle-form excitation; the q/state behaviour is the same in both builds.

module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// state | meaning
// IDLE  | counter holds, waiting for en
// RUN   | counter steps by one per edge in the direction of up
// DONE  | target reached with stop_en set, counter holds
module jk_excitation_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stop_en,
    input  logic [WIDTH-1:0] stop_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_n;
    logic             done_r;
    logic             done_n;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] n_val;
    logic [WIDTH-1:0] j_val;
    logic [WIDTH-1:0] k_val;
    logic             stop_hit;

    // Target value. Dropping en while in RUN pauses without a step, so the target is q itself.
    always_comb begin
        n_val = q_r;
        if (load) begin
            n_val = load_val;
        end else if (state_r == S_RUN && en) begin
            n_val = up ? (q_r + ONE) : (q_r - ONE);
        end
    end

    always_comb begin
        j_val = '0;
        k_val = '0;
        if (!rst) begin
`ifdef JK_TOGGLE_EN
            j_val = q_r ^ n_val;
            k_val = q_r ^ n_val;
`else
            j_val = ~q_r & n_val;
            k_val = q_r & ~n_val;
`endif
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_val[i]),
            .k   (k_val[i]),
            .q   (q_r[i])
        );
    end

    assign stop_hit = stop_en && (n_val == stop_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            done_r  <= done_n;
        end
    end

    always_comb begin
        state_n = state_r;
        if (load) begin
            state_n = en ? S_RUN : S_IDLE;
        end else begin
            unique case (state_r)
                S_IDLE: begin
                    if (en) state_n = S_RUN;
                end
                S_RUN: begin
                    if (!en)          state_n = S_IDLE;
                    else if (stop_hit) state_n = S_DONE;
                end
                S_DONE: begin
                    if (!en)          state_n = S_IDLE;
                    else if (!stop_en) state_n = S_RUN;
                end
                default: state_n = S_IDLE;
            endcase
        end
        done_n = (state_n == S_DONE);
    end

    assign q     = q_r;
    assign qnot  = ~q_r;
    assign j     = j_val;
    assign k     = k_val;
    assign done  = done_r;
    assign state = state_r;
    assign tc    = (state_r == S_RUN) && ((up && (&q_r)) || (!up && !(|q_r)));

endmodule
